button_irq_scheduler: RTL
=========================

# button_irq_scheduler

Round-robin / fixed-priority interrupt scheduler that sits between several button PIO interrupt outputs and the single CPU interrupt line. It masks and arbitrates the PIO `irq` levels, presents one winning source at a time as a vectored request, and holds it until software signals end-of-interrupt (EOI). Software services the winner by clearing that PIO's edge-capture register, then writing EOI here. It is an Avalon-MM slave, and its register access timing matches the PIO cores.

## Interface
- `NUM_SRC`, default 4: number of interrupt sources; legal range 2..16.
- `VEC_W`, default 2: vector width, equal to clog2(NUM_SRC); legal range 1..4.
- `clk`  in  1: system clock, the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `address`  in  2: register select.
- `chipselect`  in  1: slave select.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  32: write data.
- `readdata`  out  32: registered read data.
- `src_irq`  in  NUM_SRC: level interrupt requests from the PIO cores; same clock domain, no synchronizer.
- `irq`  out  1: registered interrupt to the CPU.

## Operation
- Write strobe: `wr = chipselect & ~write_n`.
- Register map:
  - Address 0, read: VECTOR, `{valid at bit 31, zeros, vector[VEC_W-1:0]}`.
  - Address 0, write: EOI; data is ignored.
  - Address 1: MASK, read/write, bits [NUM_SRC-1:0].
  - Address 2, read-only: PENDING, `src_irq & mask`.
  - Address 3: CTRL, read/write. Bit 0 is `gen` (global enable). Bit 1 is `rr` (1 = round-robin, 0 = fixed priority with the lowest index winning).
- Unused read bits return 0. Writes to address 2 are ignored.
- Request vector: `req = src_irq & mask`.
- State machine, encoded IDLE, ACTIVE, GUARD:
  - IDLE: if `gen` is set and `req` is nonzero, latch the winner into `vector`, set `valid`, set `irq`, and go to ACTIVE.
  - ACTIVE: `irq` stays at 1 and `vector` is frozen, even if the source deasserts or is masked.
    - EOI write: clear `valid` and `irq`, go to GUARD.
    - `gen` written to 0 (without an EOI in the same cycle): clear `valid` and `irq`, go to IDLE.
  - GUARD: exactly one cycle, with `irq` = 0. Always goes to IDLE. This cycle lets the PIO edge-capture clear propagate to `src_irq`.
- Round-robin pointer `ptr` (VEC_W bits):
  - The search starts at `ptr` and proceeds upward, wrapping modulo NUM_SRC.
  - On each grant, `ptr` becomes winner+1, wrapping from NUM_SRC-1 to 0.
  - `ptr` is not updated in fixed-priority mode.
- EOI writes in IDLE or GUARD are no-ops.
- MASK and CTRL writes take effect for arbitration in the cycle after the write edge.
- Reset values: `readdata` = 0, `irq` = 0, `vector` = 0, `valid` = 0, `mask` = 0, `gen` = 0, `rr` = 0, `ptr` = 0, state IDLE.
- Reset mid-operation, in any state: all of the above values are restored on the next edge, and any in-flight grant is lost.

## Timing
- `readdata` is updated on every clock edge from the address mux, regardless of `chipselect`, giving a 1-cycle read latency.
- Arbitration:
  - Given `req` nonzero in IDLE at edge n, `irq` = 1 and `valid` = 1 after edge n.
  - A VECTOR read issued at edge n+1 returns the winner after edge n+2.
- EOI at edge k:
  - `irq` = 0 after k. The state is GUARD during k..k+1 and IDLE after k+1.
  - The earliest new grant is at edge k+2.
  - `irq` is therefore low for at least 2 cycles between grants.
- Simultaneous events:
  - EOI and a CTRL write clearing `gen` in the same cycle: treated as EOI, next state GUARD.
  - A MASK write in the same cycle as the IDLE grant: the grant uses the old mask.
- `irq` is driven directly from a flop, never combinationally from `src_irq`.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `src_irq` = 4'b1111.
  - `irq` = 0, `readdata` = 0, and MASK/CTRL read back 0.
  - `irq` stays 0 afterwards, because the mask is 0.
- **Fixed priority:** MASK = 0xF, CTRL = 0x1, `src_irq` = 4'b0110.
  - `irq` goes high 1 cycle later; VECTOR reads 0x8000_0001.
  - After EOI, and with source 1 dropped, the next VECTOR reads 0x8000_0002.
- **Round-robin fairness:** CTRL = 0x3, `src_irq` held at 4'b1111, EOI after each grant.
  - Grant sequence is 0, 1, 2, 3, 0.
  - `irq` is low for exactly 2 cycles around each EOI.
- **Masking and PENDING:** MASK = 0x4, `src_irq` = 4'b0011.
  - `irq` stays 0 and PENDING reads 0.
  - Raise `src_irq[2]`: PENDING reads 0x4 and VECTOR reads 0x8000_0002.
- **Disable mid-ACTIVE:**
  - While ACTIVE, write CTRL = 0: `irq` = 0 and `valid` = 0 next cycle, and there is no re-grant while `src_irq` stays high.
  - Re-enable: a grant follows 1 cycle after the write takes effect.
- **Reset mid-ACTIVE:** assert `reset` while `irq` = 1.
  - `irq` = 0 next edge, VECTOR reads 0, `ptr` = 0.
  - After reprogramming MASK = 0xF, CTRL = 0x3 with `src_irq` = 4'b1111, the first grant is source 0.

Source files
------------

// File: rtl/button_irq_scheduler.sv
// Masks and arbitrates PIO irq levels into one vectored, EOI-held CPU interrupt.
// Latency: grant 1 cycle after req seen in IDLE; readdata 1 cycle after address.
// Backpressure: none; the slave never stalls, and a grant is held until EOI or disable.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata  - Avalon-MM slave write side (0 VECTOR/EOI, 1 MASK, 2 PENDING, 3 CTRL)
//   readdata            - registered read data, refreshed every cycle from the address mux
//   src_irq             - level requests from the PIO cores (same clock domain)
//   irq                 - registered interrupt to the CPU
module button_irq_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic               irq
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GUARD  = 2'd2;

    logic [1:0]         state;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] req;
    logic               gen;
    logic               rr;
    logic               valid;
    logic [VEC_W-1:0]   vector;
    logic [VEC_W-1:0]   ptr;

    logic               wr;
    logic               eoi_wr;
    logic               mask_wr;
    logic               ctrl_wr;

    logic               found;
    logic [VEC_W-1:0]   win;
    logic [VEC_W-1:0]   win_next;
    logic [VEC_W-1:0]   idx_v;
    int                 start_i;
    int                 idx_i;
    logic [31:0]        rd_mux;

    // Only the low writedata bits are meaningful; fold the rest away.
    logic               wdata_unused;
    assign wdata_unused = ^writedata;

    assign wr      = chipselect & ~write_n;
    assign eoi_wr  = wr && (address == 2'd0);
    assign mask_wr = wr && (address == 2'd1);
    assign ctrl_wr = wr && (address == 2'd3);
    assign req     = src_irq & mask;

    // Search upward from the start point, wrapping modulo NUM_SRC. Fixed
    // priority is the same search anchored at index 0.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        idx_i   = 0;
        idx_v   = '0;
        start_i = rr ? int'(ptr) : 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx_i = start_i + i;
            if (idx_i >= NUM_SRC) begin
                idx_i = idx_i - NUM_SRC;
            end
            idx_v = VEC_W'(idx_i);
            if (!found && req[idx_v]) begin
                found = 1'b1;
                win   = idx_v;
            end
        end
    end

    assign win_next = (int'(win) == NUM_SRC - 1) ? '0 : win + VEC_W'(1);

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: begin
                rd_mux[31]        = valid;
                rd_mux[VEC_W-1:0] = vector;
            end
            2'd1:    rd_mux[NUM_SRC-1:0] = mask;
            2'd2:    rd_mux[NUM_SRC-1:0] = req;
            default: rd_mux[1:0]         = {rr, gen};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
            vector   <= '0;
            valid    <= 1'b0;
            mask     <= '0;
            gen      <= 1'b0;
            rr       <= 1'b0;
            ptr      <= '0;
            state    <= ST_IDLE;
        end else begin
            readdata <= rd_mux;

            if (mask_wr) begin
                mask <= writedata[NUM_SRC-1:0];
            end
            if (ctrl_wr) begin
                gen <= writedata[0];
                rr  <= writedata[1];
            end

            case (state)
                ST_IDLE: begin
                    // Uses the registered mask/gen, so a same-cycle MASK or
                    // CTRL write only affects the following cycle.
                    if (gen && found) begin
                        vector <= win;
                        valid  <= 1'b1;
                        irq    <= 1'b1;
                        state  <= ST_ACTIVE;
                        if (rr) begin
                            ptr <= win_next;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // EOI takes precedence over a simultaneous disable.
                    if (eoi_wr) begin
                        valid <= 1'b0;
                        irq   <= 1'b0;
                        state <= ST_GUARD;
                    end else if (ctrl_wr && !writedata[0]) begin
                        valid <= 1'b0;
                        irq   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_GUARD: begin
                    // One dead cycle so the PIO edge-capture clear reaches src_irq.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
